down_count_monitor: RTL and testbench
=====================================

// Module: down_count_monitor
// PURPOSE
//   Sits directly downstream of the 4-bit free-running down counter and consumes its q output.
//   Checks every step for a legal decrement and flags illegal jumps. Detects underflow wrap
//   (0 -> all-ones) and keeps a running total of wraps. Every THRESH wraps it posts an event
//   carrying a snapshot of the total, over a valid/ready handshake.
// PARAMETERS
//   CNT_W   4   width of the monitored count (matches upstream counter)
//   WRAP_W  8   width of the total-wrap counter and of evt_wraps
//   THRESH  2   wraps per event (1 .. 2^WRAP_W-1)
// PORTS
//   clk          in   1       single clock, rising edge
//   reset        in   1       asynchronous, active-low (0 = in reset)
//   clear        in   1       synchronous clear, highest priority after reset
//   enable       in   1       1 = sample cnt_in this cycle; 0 = freeze all state
//   cnt_in       in   CNT_W   count value from the upstream down counter
//   wrap_pulse   out  1       1-cycle pulse: underflow wrap seen
//   step_err     out  1       1-cycle pulse: illegal step seen
//   evt_valid    out  1       event pending
//   evt_ready    in   1       consumer accepts event
//   evt_wraps    out  WRAP_W  snapshot of the total wrap count at event time
//   evt_overrun  out  1       event lost (overwritten) while pending; sticky until accepted
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; prev, batch_cnt and total_cnt = 0.
//     All outputs = 0 immediately.
//   clear=1 at clk edge: same effect as reset, but synchronous. Overrides enable and evt_ready.
//   FSM IDLE: on the first enable=1 cycle, capture cnt_in into prev and go to TRACK.
//     No checks are made on that cycle.
//   FSM TRACK, enable=1, with cur=cnt_in and dec=(prev-1) mod 2^CNT_W:
//     cur==dec : legal step.
//     cur==prev: legal stall.
//     otherwise: step_err=1 on the next cycle.
//     prev<=cur on every enabled cycle, including an erroneous one.
//   Wrap = prev==0 && cur==all-ones. Counts only as a legal step.
//     wrap_pulse=1 exactly one cycle after the sampling edge (latency 1).
//   Upstream reset to 0 from a value other than 0 or 1 is an illegal step (step_err), not a wrap.
//   On each wrap:
//     total_cnt increments and saturates at 2^WRAP_W-1.
//     batch_cnt increments. When it reaches THRESH it returns to 0 and an event fires.
//   Event fire:
//     evt_wraps <= new total_cnt (post-increment), and evt_valid <= 1 on the next cycle.
//   Handshake: a transfer occurs when evt_valid && evt_ready at a clk edge.
//     evt_valid, evt_wraps and evt_overrun are stable while evt_valid && !evt_ready.
//     After a transfer with no new fire in the same cycle: evt_valid=0 and evt_overrun=0 next cycle.
//   Simultaneous fire and transfer: the new event loads, evt_valid stays 1, and no overrun is flagged.
//   Fire while evt_valid && !evt_ready:
//     evt_wraps is overwritten with the newest total and evt_overrun <= 1.
//     evt_valid stays 1.
//   enable=0: prev, counters and FSM are held. wrap_pulse and step_err are 0.
//     The handshake still operates.
//   Arithmetic: all decrements are mod 2^CNT_W. The total never wraps (saturating);
//     batch_cnt does wrap (modulo THRESH).
//   Reset mid-handshake: the pending event is dropped with no transfer.
// TESTING (CNT_W=4, WRAP_W=8, THRESH=2 unless noted)
//   1. Release reset, enable=1, feed 3,2,1,0,15,14 -> wrap_pulse=1 only in the cycle after 15 is sampled;
//      step_err=0 throughout.
//   2. Two wraps, evt_ready=0 for 5 cycles -> evt_valid=1 and evt_wraps=8'd2 stable;
//      set evt_ready=1 -> evt_valid=0 next cycle.
//   3. Feed 9 then 3 -> step_err=1 for exactly one cycle; then 2 is a legal step and gives no error.
//      Repeat 5,5,4 -> no error.
//   4. evt_ready=0 across 4 wraps -> evt_wraps=8'd4 and evt_overrun=1;
//      accept -> both valid and overrun clear.
//   5. Event fire coincident with accept -> evt_valid stays 1, evt_wraps updated, evt_overrun=0.
//   6. Drive reset=0 between clock edges while an event is pending -> all outputs 0 with no clk edge.
//      With WRAP_W=2 and THRESH=1, 5 wraps -> evt_wraps saturates at 2'd3.

Source files
------------

// File: rtl/down_count_monitor_if.sv
// Event handshake bundle between down_count_monitor and its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds evt_ready low; producer keeps the payload stable.
//
// Signals
//   evt_valid    producer -> consumer   event pending
//   evt_ready    consumer -> producer   consumer accepts event this cycle
//   evt_wraps    producer -> consumer   snapshot of the total wrap count
//   evt_overrun  producer -> consumer   an older event was overwritten while pending
interface down_count_monitor_if #(
  parameter int WRAP_W = 8
);
  logic              evt_valid;
  logic              evt_ready;
  logic [WRAP_W-1:0] evt_wraps;
  logic              evt_overrun;

  modport master (
    output evt_valid,
    output evt_wraps,
    output evt_overrun,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_wraps,
    input  evt_overrun,
    output evt_ready
  );
endinterface

// File: rtl/down_count_monitor.sv
// Watches a free-running down counter: flags illegal steps, counts underflow wraps, posts events.
// Latency: wrap_pulse/step_err/evt_* all registered, 1 cycle after the sampling edge.
// Backpressure: pending event held stable until accepted; a newer event overwrites it and sets overrun.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   clear        synchronous clear (same effect as reset), beats enable and evt_ready
//   enable       1 = sample cnt_in this cycle, 0 = freeze tracking state
//   cnt_in       count from the upstream down counter
//   wrap_pulse   1-cycle pulse: legal 0 -> all-ones step seen
//   step_err     1-cycle pulse: step was neither a decrement nor a stall
//   evt          event handshake (master side)
module down_count_monitor #(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 8,
  parameter int THRESH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     cnt_in,
  output logic                 wrap_pulse,
  output logic                 step_err,
  down_count_monitor_if.master evt
);

  localparam logic [WRAP_W-1:0] THRESH_V = WRAP_W'(THRESH);
  localparam logic [WRAP_W-1:0] TOTAL_MAX = {WRAP_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  prev;
  logic [WRAP_W-1:0] batch_cnt;
  logic [WRAP_W-1:0] total_cnt;

  // Step classification against the previously sampled count.
  logic [CNT_W-1:0]  dec;
  logic              step_ok;
  logic              is_wrap;
  logic              chk;
  logic              wrap_hit;
  logic              err_hit;

  // Counter next values for a wrap.
  logic [WRAP_W-1:0] total_nxt;
  logic [WRAP_W-1:0] batch_inc;
  logic              batch_full;
  logic              fire;
  logic              xfer;

  always_comb begin
    dec      = prev - CNT_W'(1);
    step_ok  = (cnt_in == dec) || (cnt_in == prev);
    // 0 -> all-ones is the decrement case, so a wrap is always a legal step.
    is_wrap  = (prev == '0) && (cnt_in == {CNT_W{1'b1}});
    chk      = enable && (state == TRACK);
    wrap_hit = chk && is_wrap;
    err_hit  = chk && !step_ok;
  end

  always_comb begin
    total_nxt  = (total_cnt == TOTAL_MAX) ? total_cnt : total_cnt + WRAP_W'(1);
    batch_inc  = batch_cnt + WRAP_W'(1);
    batch_full = (batch_inc == THRESH_V);
    fire       = wrap_hit && batch_full;
    xfer       = evt.evt_valid && evt.evt_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      prev            <= '0;
      batch_cnt       <= '0;
      total_cnt       <= '0;
      wrap_pulse      <= 1'b0;
      step_err        <= 1'b0;
      evt.evt_valid   <= 1'b0;
      evt.evt_wraps   <= '0;
      evt.evt_overrun <= 1'b0;
    end else if (clear) begin
      state           <= IDLE;
      prev            <= '0;
      batch_cnt       <= '0;
      total_cnt       <= '0;
      wrap_pulse      <= 1'b0;
      step_err        <= 1'b0;
      evt.evt_valid   <= 1'b0;
      evt.evt_wraps   <= '0;
      evt.evt_overrun <= 1'b0;
    end else begin
      // Pulses are only ever high for the cycle after a checked sample.
      wrap_pulse <= wrap_hit;
      step_err   <= err_hit;

      if (enable) begin
        case (state)
          IDLE: begin
            // First sample only seeds prev; nothing to compare against yet.
            prev  <= cnt_in;
            state <= TRACK;
          end
          TRACK: begin
            // prev follows cnt_in even on an error so one glitch costs one flag.
            prev <= cnt_in;
            if (wrap_hit) begin
              total_cnt <= total_nxt;
              batch_cnt <= batch_full ? '0 : batch_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Handshake runs regardless of enable.
      if (fire) begin
        evt.evt_valid   <= 1'b1;
        evt.evt_wraps   <= total_nxt;
        // Only an event still sitting unaccepted is lost; a same-cycle accept saved it.
        evt.evt_overrun <= evt.evt_valid && !evt.evt_ready;
      end else if (xfer) begin
        evt.evt_valid   <= 1'b0;
        evt.evt_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
module tb_down_count_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [3:0] cur = 4'd0;

  logic a_wp, a_se, b_wp, b_se;

  down_count_monitor_if #(.WRAP_W(8)) if_a ();
  down_count_monitor_if #(.WRAP_W(2)) if_b ();

  assign if_a.evt_ready = rdy;
  assign if_b.evt_ready = rdy;

  down_count_monitor #(.CNT_W(4), .WRAP_W(8), .THRESH(2)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .cnt_in(cnt),
    .wrap_pulse(a_wp), .step_err(a_se), .evt(if_a.master)
  );

  down_count_monitor #(.CNT_W(4), .WRAP_W(2), .THRESH(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .cnt_in(cnt),
    .wrap_pulse(b_wp), .step_err(b_se), .evt(if_b.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model for dut_a (THRESH=2, WRAP_W=8), in terms of the observable rules:
  // total wraps since clear, events every THRESH-th wrap, pending/lost event flags.
  bit m_track;
  int m_prev, m_total, m_nwraps, m_wr;
  bit m_vld, m_ovr, m_wp, m_se;

  task automatic model_reset();
    m_track = 0; m_prev = 0; m_total = 0; m_nwraps = 0; m_wr = 0;
    m_vld = 0; m_ovr = 0; m_wp = 0; m_se = 0;
  endtask

  task automatic model_edge(input bit c, input bit e, input int n, input bit r);
    bit fire;
    bit xfer;
    if (c) begin
      model_reset();
    end else begin
      fire = 0;
      m_wp = 0;
      m_se = 0;
      xfer = m_vld && r;
      if (e) begin
        if (!m_track) begin
          m_track = 1;
        end else begin
          if (!(n == (m_prev + 15) % 16 || n == m_prev)) m_se = 1;
          if (m_prev == 0 && n == 15) begin
            m_wp = 1;
            m_nwraps++;
            m_total = (m_total + 1 > 255) ? 255 : m_total + 1;
            if (m_nwraps % 2 == 0) fire = 1;
          end
        end
        m_prev = n;
      end
      if (fire) begin
        m_ovr = m_vld && !r;
        m_vld = 1;
        m_wr  = m_total;
      end else if (xfer) begin
        m_vld = 0;
        m_ovr = 0;
      end
    end
  endtask

  task automatic cyc(input bit c, input bit e, input logic [3:0] n, input bit r);
    clear = c; enable = e; cnt = n; rdy = r;
    if (e) cur = n;
    @(posedge clk);
    #1;
    model_edge(c, e, int'(n), r);
  endtask

  // Count down from cur to 0 then step to 15 (one wrap); ready level chosen separately
  // for the countdown and for the wrapping edge.
  task automatic do_wrap(input bit r_down, input bit r_wrap);
    while (cur != 4'd0) cyc(1'b0, 1'b1, cur - 4'd1, r_down);
    cyc(1'b0, 1'b1, 4'd15, r_wrap);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wp"},   a_wp, m_wp);
    check({tag, ".se"},   a_se, m_se);
    check({tag, ".vld"},  if_a.evt_valid, m_vld);
    check({tag, ".wr"},   if_a.evt_wraps, m_wr);
    check({tag, ".ovr"},  if_a.evt_overrun, m_ovr);
  endtask

  typedef struct {
    logic       clr, en;
    logic [3:0] n;
    logic       r;
    logic       wp, se, vld;
    logic [7:0] wr;
    logic       ovr;
  } vec_t;

  function automatic vec_t mk(input logic clr, input logic en, input logic [3:0] n, input logic r,
                              input logic wp, input logic se);
    vec_t v;
    v.clr = clr; v.en = en; v.n = n; v.r = r;
    v.wp = wp; v.se = se; v.vld = 1'b0; v.wr = 8'd0; v.ovr = 1'b0;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    // Stepping sequences: wrap detection, stall, enable freeze, illegal jumps, clear.
    tbl[0]  = mk(0, 1, 4'd3,  1, 0, 0);  // seed, no check
    tbl[1]  = mk(0, 1, 4'd2,  1, 0, 0);
    tbl[2]  = mk(0, 1, 4'd1,  1, 0, 0);
    tbl[3]  = mk(0, 1, 4'd0,  1, 0, 0);
    tbl[4]  = mk(0, 1, 4'd15, 1, 1, 0);  // underflow wrap
    tbl[5]  = mk(0, 1, 4'd14, 1, 0, 0);
    tbl[6]  = mk(0, 0, 4'd7,  1, 0, 0);  // frozen: junk ignored
    tbl[7]  = mk(0, 1, 4'd13, 1, 0, 0);  // prev still 14
    tbl[8]  = mk(1, 1, 4'd0,  1, 0, 0);  // clear
    tbl[9]  = mk(0, 1, 4'd10, 1, 0, 0);  // seed
    tbl[10] = mk(0, 1, 4'd9,  1, 0, 0);
    tbl[11] = mk(0, 1, 4'd3,  1, 0, 1);  // 9 -> 3 illegal
    tbl[12] = mk(0, 1, 4'd2,  1, 0, 0);  // legal from 3
    tbl[13] = mk(0, 1, 4'd2,  1, 0, 0);  // stall
    tbl[14] = mk(1, 0, 4'd0,  1, 0, 0);  // clear overrides enable=0
    tbl[15] = mk(0, 1, 4'd5,  1, 0, 0);  // seed
    tbl[16] = mk(0, 1, 4'd5,  1, 0, 0);  // stall
    tbl[17] = mk(0, 1, 4'd4,  1, 0, 0);
    tbl[18] = mk(0, 1, 4'd0,  1, 0, 1);  // upstream reset 4 -> 0 is an error
    tbl[19] = mk(0, 1, 4'd15, 1, 1, 0);  // 0 -> 15 is a wrap

    model_reset();
    #1;
    check("rst.wp",  a_wp, 0);
    check("rst.se",  a_se, 0);
    check("rst.vld", if_a.evt_valid, 0);
    check("rst.wr",  if_a.evt_wraps, 0);
    check("rst.ovr", if_a.evt_overrun, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].clr, tbl[i].en, tbl[i].n, tbl[i].r);
      check($sformatf("tbl%0d.wp", i),  a_wp, tbl[i].wp);
      check($sformatf("tbl%0d.se", i),  a_se, tbl[i].se);
      check($sformatf("tbl%0d.vld", i), if_a.evt_valid, tbl[i].vld);
      check($sformatf("tbl%0d.wr", i),  if_a.evt_wraps, tbl[i].wr);
      check($sformatf("tbl%0d.ovr", i), if_a.evt_overrun, tbl[i].ovr);
    end

    // Two wraps with consumer stalled: payload stable, then accept.
    cyc(1, 1, 4'd0, 0);
    cyc(0, 1, 4'd0, 0);
    cyc(0, 1, 4'd15, 0);
    check("hs.wrap1_vld", if_a.evt_valid, 0);
    do_wrap(0, 0);
    check("hs.wrap2_vld", if_a.evt_valid, 1);
    check("hs.wrap2_wr",  if_a.evt_wraps, 2);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, cur, 0);
      check($sformatf("hs.hold%0d_vld", k), if_a.evt_valid, 1);
      check($sformatf("hs.hold%0d_wr", k),  if_a.evt_wraps, 2);
      check($sformatf("hs.hold%0d_ovr", k), if_a.evt_overrun, 0);
    end
    cyc(0, 0, cur, 1);
    check("hs.accept_vld", if_a.evt_valid, 0);

    // Four wraps unaccepted: second event overwrites the first.
    cyc(1, 1, 4'd0, 0);
    cyc(0, 1, 4'd0, 0);
    cyc(0, 1, 4'd15, 0);
    for (int k = 0; k < 3; k++) do_wrap(0, 0);
    check("ovr.vld", if_a.evt_valid, 1);
    check("ovr.wr",  if_a.evt_wraps, 4);
    check("ovr.ovr", if_a.evt_overrun, 1);
    cyc(0, 0, cur, 1);
    check("ovr.acc_vld", if_a.evt_valid, 0);
    check("ovr.acc_ovr", if_a.evt_overrun, 0);

    // Fire in the same cycle as an accept: new event loads, no overrun.
    cyc(1, 1, 4'd0, 0);
    cyc(0, 1, 4'd0, 0);
    cyc(0, 1, 4'd15, 0);
    do_wrap(0, 0);
    do_wrap(0, 0);
    check("co.pend_wr", if_a.evt_wraps, 2);
    do_wrap(0, 1);
    check("co.vld", if_a.evt_valid, 1);
    check("co.wr",  if_a.evt_wraps, 4);
    check("co.ovr", if_a.evt_overrun, 0);

    // Asynchronous reset between edges while an event is pending.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst.wp",   a_wp, 0);
    check("arst.se",   a_se, 0);
    check("arst.vld",  if_a.evt_valid, 0);
    check("arst.wr",   if_a.evt_wraps, 0);
    check("arst.ovr",  if_a.evt_overrun, 0);
    check("arst.bvld", if_b.evt_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Saturation on the narrow instance: THRESH=1, WRAP_W=2.
    cyc(0, 1, 4'd0, 1);
    cyc(0, 1, 4'd15, 1);
    check("sat.w1_vld", if_b.evt_valid, 1);
    check("sat.w1_wr",  if_b.evt_wraps, 1);
    for (int k = 2; k <= 5; k++) begin
      do_wrap(1, 1);
      check($sformatf("sat.w%0d_vld", k), if_b.evt_valid, 1);
      check($sformatf("sat.w%0d_wr", k),  if_b.evt_wraps, (k > 3) ? 3 : k);
    end

    // Randomised run against the reference model.
    cyc(1, 1, 4'd0, 0);
    check_model("rnd.clr");
    for (int i = 0; i < 3000; i++) begin
      int sel;
      bit c, e, r;
      logic [3:0] n;
      sel = $urandom_range(0, 99);
      if (sel < 70)      n = cur - 4'd1;
      else if (sel < 85) n = cur;
      else               n = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 7) != 0);
      r = ($urandom_range(0, 1) != 0);
      c = ($urandom_range(0, 299) == 0);
      cyc(c, e, n, r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
